// File: rtl/rsv_sched_pkg.sv
// ---------------------------------------------------------------------------
// rsv_sched_pkg : widths and entry types for the reservation station
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rsv_sched_pkg;

  localparam int NUM_UOPS      = 128;
  localparam int PHYSFILE_SIZE = 128;
  localparam int ROB_SIZE      = 64;
  localparam int RSV_SIZE      = 8;

  localparam int UOP_W     = $clog2(NUM_UOPS);
  localparam int PTAG_W    = $clog2(PHYSFILE_SIZE);
  localparam int ROB_W     = $clog2(ROB_SIZE);
  localparam int RSV_IDX_W = $clog2(RSV_SIZE);
  localparam int CNT_W     = $clog2(RSV_SIZE + 1);

  typedef struct packed {
    logic [UOP_W-1:0]  uop;
    logic [PTAG_W-1:0] src1_tag;
    logic              src1_rdy;
    logic [PTAG_W-1:0] src2_tag;
    logic              src2_rdy;
    logic [PTAG_W-1:0] dest_tag;
    logic [ROB_W-1:0]  rob_id;
  } rsv_entry_t;

  typedef struct packed {
    logic [UOP_W-1:0]  uop;
    logic [PTAG_W-1:0] src1_tag;
    logic [PTAG_W-1:0] src2_tag;
    logic [PTAG_W-1:0] dest_tag;
    logic [ROB_W-1:0]  rob_id;
  } rsv_issue_t;

  // Index of the lowest set bit; also converts a one-hot vector to an index.
  function automatic logic [RSV_IDX_W-1:0] first_set(input logic [RSV_SIZE-1:0] v);
    first_set = '0;
    for (int i = RSV_SIZE - 1; i >= 0; i--) begin
      if (v[i]) first_set = RSV_IDX_W'(i);
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/rsv_sched_if.sv
// ---------------------------------------------------------------------------
// rsv_sched_if : dispatch, wakeup and issue signals of the reservation station
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rsv_sched_if;
  import rsv_sched_pkg::*;

  logic              flush;
  logic              alloc_valid;
  logic              alloc_ready;
  logic [UOP_W-1:0]  alloc_uop;
  logic [PTAG_W-1:0] alloc_src1_tag;
  logic [PTAG_W-1:0] alloc_src2_tag;
  logic              alloc_src1_rdy;
  logic              alloc_src2_rdy;
  logic [PTAG_W-1:0] alloc_dest_tag;
  logic [ROB_W-1:0]  alloc_rob_id;
  logic              wakeup_valid;
  logic [PTAG_W-1:0] wakeup_tag;
  logic              issue_valid;
  logic              issue_ready;
  logic [UOP_W-1:0]  issue_uop;
  logic [PTAG_W-1:0] issue_src1_tag;
  logic [PTAG_W-1:0] issue_src2_tag;
  logic [PTAG_W-1:0] issue_dest_tag;
  logic [ROB_W-1:0]  issue_rob_id;
  logic [CNT_W-1:0]  count;

  // The scheduler side.
  modport slave (
    input  flush, alloc_valid, alloc_uop, alloc_src1_tag, alloc_src2_tag,
           alloc_src1_rdy, alloc_src2_rdy, alloc_dest_tag, alloc_rob_id,
           wakeup_valid, wakeup_tag, issue_ready,
    output alloc_ready, issue_valid, issue_uop, issue_src1_tag, issue_src2_tag,
           issue_dest_tag, issue_rob_id, count
  );

  // Dispatch / result bus / functional unit side.
  modport master (
    output flush, alloc_valid, alloc_uop, alloc_src1_tag, alloc_src2_tag,
           alloc_src1_rdy, alloc_src2_rdy, alloc_dest_tag, alloc_rob_id,
           wakeup_valid, wakeup_tag, issue_ready,
    input  alloc_ready, issue_valid, issue_uop, issue_src1_tag, issue_src2_tag,
           issue_dest_tag, issue_rob_id, count
  );

endinterface

`default_nettype wire

// File: rtl/rsv_sched_age_matrix_sel.sv
// ---------------------------------------------------------------------------
// age_matrix_sel : age matrix storage and oldest-ready one-hot select
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module age_matrix_sel
  import rsv_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 alloc_en_i,
  input  logic [RSV_IDX_W-1:0] alloc_idx_i,
  input  logic                 free_en_i,
  input  logic [RSV_IDX_W-1:0] free_idx_i,
  input  logic [RSV_SIZE-1:0]  valid_i,
  input  logic [RSV_SIZE-1:0]  ready_i,
  output logic [RSV_SIZE-1:0]  sel_o,
  output logic                 sel_any_o
);

  // age_q[i][j] = 1 means entry i is older than entry j.
  logic [RSV_SIZE-1:0] age_q [RSV_SIZE];
  logic [RSV_SIZE-1:0] age_d [RSV_SIZE];

  always_comb begin
    age_d = age_q;
    if (free_en_i) age_d[free_idx_i] = '0;
    if (alloc_en_i) begin
      age_d[alloc_idx_i] = '0;
      for (int j = 0; j < RSV_SIZE; j++) begin
        if (valid_i[j] && !(free_en_i && (free_idx_i == RSV_IDX_W'(j))))
          age_d[j][alloc_idx_i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      for (int i = 0; i < RSV_SIZE; i++) age_q[i] <= '0;
    end else begin
      age_q <= age_d;
    end
  end

  for (genvar i = 0; i < RSV_SIZE; i++) begin : g_sel
    logic older_rdy;
    always_comb begin
      older_rdy = 1'b0;
      for (int j = 0; j < RSV_SIZE; j++) older_rdy = older_rdy | (ready_i[j] & age_q[j][i]);
    end
    assign sel_o[i] = ready_i[i] & ~older_rdy;
  end

  assign sel_any_o = |sel_o;

endmodule

`default_nettype wire

// File: rtl/rsv_sched.sv
// ---------------------------------------------------------------------------
// rsv_sched : reservation station issuing the oldest fully-ready uop
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rsv_sched
  import rsv_sched_pkg::*;
(
  input logic       clk,
  input logic       rst,
  rsv_sched_if.slave rs
);

  logic [RSV_SIZE-1:0] valid_q, valid_d;
  rsv_entry_t          ent_q [RSV_SIZE];
  rsv_entry_t          ent_d [RSV_SIZE];
  logic [CNT_W-1:0]    count_q, count_d;
  logic                issue_valid_q, issue_valid_d;
  rsv_issue_t          iss_q, iss_d;

  logic [RSV_SIZE-1:0]  w_ready;
  logic [RSV_SIZE-1:0]  w_sel;
  logic                 w_sel_any;
  logic [RSV_IDX_W-1:0] w_sel_idx;
  logic [RSV_IDX_W-1:0] w_alloc_idx;
  logic                 w_alloc;
  logic                 w_load;
  logic                 w_fire;
  rsv_entry_t           w_new;

  for (genvar i = 0; i < RSV_SIZE; i++) begin : g_ready
    assign w_ready[i] = valid_q[i] & ent_q[i].src1_rdy & ent_q[i].src2_rdy;
  end

  // alloc_ready looks only at the start-of-cycle count.
  assign rs.alloc_ready = (count_q != CNT_W'(RSV_SIZE));
  assign w_alloc        = rs.alloc_valid & rs.alloc_ready;
  assign w_alloc_idx    = first_set(~valid_q);
  assign w_load         = ~issue_valid_q | rs.issue_ready;
  assign w_fire         = w_load & w_sel_any;
  assign w_sel_idx      = first_set(w_sel);

  age_matrix_sel u_age (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (rs.flush),
    .alloc_en_i (w_alloc),
    .alloc_idx_i(w_alloc_idx),
    .free_en_i  (w_fire),
    .free_idx_i (w_sel_idx),
    .valid_i    (valid_q),
    .ready_i    (w_ready),
    .sel_o      (w_sel),
    .sel_any_o  (w_sel_any)
  );

  // Incoming uop, with same-cycle bypass of the result bus.
  always_comb begin
    w_new          = '0;
    w_new.uop      = rs.alloc_uop;
    w_new.src1_tag = rs.alloc_src1_tag;
    w_new.src2_tag = rs.alloc_src2_tag;
    w_new.dest_tag = rs.alloc_dest_tag;
    w_new.rob_id   = rs.alloc_rob_id;
    w_new.src1_rdy = rs.alloc_src1_rdy | (rs.wakeup_valid & (rs.alloc_src1_tag == rs.wakeup_tag));
    w_new.src2_rdy = rs.alloc_src2_rdy | (rs.wakeup_valid & (rs.alloc_src2_tag == rs.wakeup_tag));
  end

  always_comb begin
    valid_d       = valid_q;
    ent_d         = ent_q;
    issue_valid_d = issue_valid_q;
    iss_d         = iss_q;

    if (rs.wakeup_valid) begin
      for (int i = 0; i < RSV_SIZE; i++) begin
        if (valid_q[i] && (ent_q[i].src1_tag == rs.wakeup_tag)) ent_d[i].src1_rdy = 1'b1;
        if (valid_q[i] && (ent_q[i].src2_tag == rs.wakeup_tag)) ent_d[i].src2_rdy = 1'b1;
      end
    end

    if (w_load) begin
      issue_valid_d = w_sel_any;
      if (w_sel_any) begin
        valid_d[w_sel_idx] = 1'b0;
        iss_d.uop          = ent_q[w_sel_idx].uop;
        iss_d.src1_tag     = ent_q[w_sel_idx].src1_tag;
        iss_d.src2_tag     = ent_q[w_sel_idx].src2_tag;
        iss_d.dest_tag     = ent_q[w_sel_idx].dest_tag;
        iss_d.rob_id       = ent_q[w_sel_idx].rob_id;
      end
    end

    if (w_alloc) begin
      valid_d[w_alloc_idx] = 1'b1;
      ent_d[w_alloc_idx]   = w_new;
    end

    count_d = count_q + CNT_W'(w_alloc) - CNT_W'(w_fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      iss_q         <= '0;
      for (int i = 0; i < RSV_SIZE; i++) ent_q[i] <= '0;
    end else if (rs.flush) begin
      valid_q       <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      ent_q         <= ent_d;
      count_q       <= count_d;
      issue_valid_q <= issue_valid_d;
      iss_q         <= iss_d;
    end
  end

  assign rs.issue_valid    = issue_valid_q;
  assign rs.issue_uop      = iss_q.uop;
  assign rs.issue_src1_tag = iss_q.src1_tag;
  assign rs.issue_src2_tag = iss_q.src2_tag;
  assign rs.issue_dest_tag = iss_q.dest_tag;
  assign rs.issue_rob_id   = iss_q.rob_id;
  assign rs.count          = count_q;

endmodule

`default_nettype wire

// File: tb/tb_rsv_sched.sv
// ---------------------------------------------------------------------------
// tb_rsv_sched : directed and random checks of rsv_sched against an age-queue model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rsv_sched;
  import rsv_sched_pkg::*;

  logic clk;
  logic rst;
  rsv_sched_if bus ();

  rsv_sched dut (
    .clk(clk),
    .rst(rst),
    .rs (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int uop;
    int s1;
    bit s1r;
    int s2;
    bit s2r;
    int dest;
    int rob;
  } m_t;

  // Model: entries kept in allocation order, so the front-most ready entry is the oldest.
  m_t mq[$];
  bit m_iv;
  m_t m_iss;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit can_alloc;
    bit load;
    int pick;
    m_t n;
    if (rst || bus.flush) begin
      mq.delete();
      m_iv = 1'b0;
    end else begin
      can_alloc = (mq.size() != RSV_SIZE);
      load      = !m_iv || bus.issue_ready;
      pick      = -1;
      foreach (mq[i]) if (pick < 0 && mq[i].s1r && mq[i].s2r) pick = i;
      if (bus.wakeup_valid) begin
        foreach (mq[i]) begin
          if (mq[i].s1 == int'(bus.wakeup_tag)) mq[i].s1r = 1'b1;
          if (mq[i].s2 == int'(bus.wakeup_tag)) mq[i].s2r = 1'b1;
        end
      end
      if (load) begin
        if (pick >= 0) begin
          m_iss = mq[pick];
          mq.delete(pick);
          m_iv = 1'b1;
        end else begin
          m_iv = 1'b0;
        end
      end
      if (bus.alloc_valid && can_alloc) begin
        n.uop  = int'(bus.alloc_uop);
        n.s1   = int'(bus.alloc_src1_tag);
        n.s2   = int'(bus.alloc_src2_tag);
        n.dest = int'(bus.alloc_dest_tag);
        n.rob  = int'(bus.alloc_rob_id);
        n.s1r  = bus.alloc_src1_rdy || (bus.wakeup_valid && bus.alloc_src1_tag == bus.wakeup_tag);
        n.s2r  = bus.alloc_src2_rdy || (bus.wakeup_valid && bus.alloc_src2_tag == bus.wakeup_tag);
        mq.push_back(n);
      end
    end
  endtask

  task automatic compare_all();
    check("alloc_ready", 32'(bus.alloc_ready), 32'(mq.size() != RSV_SIZE));
    check("count", 32'(bus.count), 32'(mq.size()));
    check("issue_valid", 32'(bus.issue_valid), 32'(m_iv));
    if (m_iv) begin
      check("issue_uop", 32'(bus.issue_uop), 32'(m_iss.uop));
      check("issue_src1_tag", 32'(bus.issue_src1_tag), 32'(m_iss.s1));
      check("issue_src2_tag", 32'(bus.issue_src2_tag), 32'(m_iss.s2));
      check("issue_dest_tag", 32'(bus.issue_dest_tag), 32'(m_iss.dest));
      check("issue_rob_id", 32'(bus.issue_rob_id), 32'(m_iss.rob));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_idle();
    bus.flush          = 1'b0;
    bus.alloc_valid    = 1'b0;
    bus.wakeup_valid   = 1'b0;
    bus.wakeup_tag     = '0;
    bus.issue_ready    = 1'b1;
    bus.alloc_uop      = '0;
    bus.alloc_src1_tag = '0;
    bus.alloc_src2_tag = '0;
    bus.alloc_src1_rdy = 1'b0;
    bus.alloc_src2_rdy = 1'b0;
    bus.alloc_dest_tag = '0;
    bus.alloc_rob_id   = '0;
  endtask

  task automatic set_alloc(input int uop, input int t1, input bit r1, input int t2, input bit r2,
                           input int dest, input int rob);
    bus.alloc_valid    = 1'b1;
    bus.alloc_uop      = UOP_W'(uop);
    bus.alloc_src1_tag = PTAG_W'(t1);
    bus.alloc_src1_rdy = r1;
    bus.alloc_src2_tag = PTAG_W'(t2);
    bus.alloc_src2_rdy = r2;
    bus.alloc_dest_tag = PTAG_W'(dest);
    bus.alloc_rob_id   = ROB_W'(rob);
  endtask

  initial begin
    m_iss = '{default: 0};
    set_idle();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    check("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    check("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_issue_uop", 32'(bus.issue_uop), 32'd0);
    check("rst_issue_rob", 32'(bus.issue_rob_id), 32'd0);

    // Single ready uop: visible on issue two cycles after alloc_valid.
    set_alloc(5, 1, 1'b1, 2, 1'b1, 9, 3);
    cycle();
    set_idle();
    cycle();
    check("s1_issue_valid", 32'(bus.issue_valid), 32'd1);
    check("s1_issue_uop", 32'(bus.issue_uop), 32'd5);
    check("s1_issue_rob", 32'(bus.issue_rob_id), 32'd3);
    check("s1_count", 32'(bus.count), 32'd0);
    cycle();

    // Younger ready uop overtakes an older waiting one; wakeup releases the older.
    set_alloc(10, 40, 1'b0, 3, 1'b1, 11, 4);
    cycle();
    set_alloc(11, 5, 1'b1, 6, 1'b1, 12, 5);
    cycle();
    set_idle();
    cycle();
    check("s2_first_uop", 32'(bus.issue_uop), 32'd11);
    cycle();
    check("s2_gap_valid", 32'(bus.issue_valid), 32'd0);
    bus.wakeup_valid = 1'b1;
    bus.wakeup_tag   = PTAG_W'(40);
    cycle();
    set_idle();
    cycle();
    check("s2_woken_valid", 32'(bus.issue_valid), 32'd1);
    check("s2_woken_uop", 32'(bus.issue_uop), 32'd10);
    cycle();

    // Fill the station behind a stalled issue register, then drain in age order.
    bus.issue_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      set_alloc(20 + k, 1, 1'b1, 2, 1'b1, 30 + k, k);
      bus.issue_ready = 1'b0;
      cycle();
    end
    check("s3_full_count", 32'(bus.count), 32'd8);
    check("s3_full_ready", 32'(bus.alloc_ready), 32'd0);
    check("s3_held_uop", 32'(bus.issue_uop), 32'd20);
    set_idle();
    cycle();
    check("s3_next_uop", 32'(bus.issue_uop), 32'd21);
    check("s3_ready_back", 32'(bus.alloc_ready), 32'd1);
    for (int k = 0; k < 9; k++) cycle();
    check("s3_drained", 32'(bus.issue_valid), 32'd0);

    // Same-cycle wakeup bypass on allocation.
    set_alloc(50, 7, 1'b1, 17, 1'b0, 51, 6);
    bus.wakeup_valid = 1'b1;
    bus.wakeup_tag   = PTAG_W'(17);
    cycle();
    set_idle();
    cycle();
    check("s4_bypass_valid", 32'(bus.issue_valid), 32'd1);
    check("s4_bypass_uop", 32'(bus.issue_uop), 32'd50);
    cycle();

    // Flush with pending entries, a stalled issue and a concurrent alloc.
    for (int k = 0; k < 5; k++) begin
      set_alloc(60 + k, 1, 1'b1, 2, 1'b1, 0, k);
      bus.issue_ready = 1'b0;
      cycle();
    end
    check("s5_pre_count", 32'(bus.count), 32'd4);
    set_alloc(70, 1, 1'b1, 2, 1'b1, 0, 9);
    bus.issue_ready = 1'b0;
    bus.flush       = 1'b1;
    cycle();
    check("s5_flush_count", 32'(bus.count), 32'd0);
    check("s5_flush_valid", 32'(bus.issue_valid), 32'd0);
    set_idle();
    cycle();
    check("s5_after_count", 32'(bus.count), 32'd0);
    check("s5_after_valid", 32'(bus.issue_valid), 32'd0);

    // Random traffic over a small tag space so wakeups hit often.
    for (int c = 0; c < 600; c++) begin
      bus.flush        = ($urandom_range(0, 79) == 0);
      bus.alloc_valid  = ($urandom_range(0, 9) < 6);
      bus.alloc_uop      = UOP_W'($urandom);
      bus.alloc_src1_tag = PTAG_W'($urandom_range(0, 15));
      bus.alloc_src2_tag = PTAG_W'($urandom_range(0, 15));
      bus.alloc_src1_rdy = ($urandom_range(0, 2) != 0);
      bus.alloc_src2_rdy = ($urandom_range(0, 2) != 0);
      bus.alloc_dest_tag = PTAG_W'($urandom);
      bus.alloc_rob_id   = ROB_W'($urandom);
      bus.wakeup_valid = ($urandom_range(0, 1) != 0);
      bus.wakeup_tag   = PTAG_W'($urandom_range(0, 15));
      bus.issue_ready  = ($urandom_range(0, 9) < 7);
      cycle();
    end
    set_idle();
    for (int c = 0; c < 12; c++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
